instr_fetch: RTL and testbench



---
 rtl/instr_fetch.sv | 130 +++++++++++++
 tb/tb_instr_fetch.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// ---------------------------------------------------------------------------
// instr_fetch
//   Fetch-side initiator for the synchronous instruction ROM. Issues one
//   byte address per cycle and tags each request with its PC. The word that
//   returns one edge later is written into a 2-entry output FIFO, which
//   presents instructions to decode through a valid/ready handshake.
//   A redirect flushes the in-flight request and every buffered entry, then
//   restarts fetch at the word-aligned target.
//
// Ports
//   clk            clock
//   rst_n          asynchronous active-low reset
//   fetch_en       allow new ROM requests; buffered entries still drain
//   rom_addr       byte address to the ROM (combinational copy of pc_fetch)
//   rom_data       ROM registered output for the address sampled last edge
//   redirect_valid one-cycle redirect strobe, overrides everything else
//   redirect_pc    redirect target; bits [1:0] are ignored
//   out_valid      FIFO head valid
//   out_instr      FIFO head instruction
//   out_pc         byte PC of out_instr
//   out_ready      decode accepts the head this cycle
// ---------------------------------------------------------------------------
module instr_fetch #(
    parameter int                ADDR_W   = 14,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    // Two entries are the minimum for one instruction per cycle: one slot
    // holds the head being consumed while the other catches the word that
    // was already in flight when the head was issued.
    parameter int                DEPTH    = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [31:0]       rom_data,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              out_valid,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_pc,
    input  logic              out_ready
);

    localparam logic [1:0] DEPTH_L = 2'(DEPTH);

    logic [ADDR_W-1:0] pc_fetch;
    logic [ADDR_W-1:0] inflight_pc;
    logic              inflight_v;

    logic [31:0]       fifo_instr [2];
    logic [ADDR_W-1:0] fifo_pc    [2];
    logic              wr_ptr;
    logic              rd_ptr;
    logic [1:0]        count;

    logic              pop;
    logic              push;
    logic              issue;
    logic [1:0]        occupancy;

    // The target is always word aligned, so its low bits carry no information.
    logic              unused_redirect_lsbs;
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    assign rom_addr  = pc_fetch;
    assign out_valid = (count != 2'd0);
    assign out_instr = out_valid ? fifo_instr[rd_ptr] : 32'd0;
    assign out_pc    = out_valid ? fifo_pc[rd_ptr]    : '0;

    assign pop  = out_valid & out_ready;
    assign push = inflight_v;

    // Counting the in-flight request as occupied guarantees its word always
    // has a slot when it lands; a pop this edge frees one slot in advance.
    assign occupancy = count + {1'b0, inflight_v};
    assign issue     = fetch_en & ~redirect_valid & ((occupancy < DEPTH_L) | pop);

    // Fetch PC, in-flight tag and FIFO bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_fetch    <= RESET_PC;
            inflight_pc <= '0;
            inflight_v  <= 1'b0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            count       <= 2'd0;
        end else if (redirect_valid) begin
            // Any pending rom_data belongs to the old path and is dropped.
            pc_fetch   <= {redirect_pc[ADDR_W-1:2], 2'b00};
            inflight_v <= 1'b0;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            count      <= 2'd0;
        end else begin
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
            if (issue) begin
                inflight_pc <= pc_fetch;
                inflight_v  <= 1'b1;
                pc_fetch    <= pc_fetch + ADDR_W'(4);
            end else begin
                inflight_v <= 1'b0;
            end
        end
    end

    // FIFO storage. Entries are not cleared by a redirect; the pointers and
    // count are, which makes stale contents unreachable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                fifo_instr[i] <= 32'd0;
                fifo_pc[i]    <= '0;
            end
        end else if (push && !redirect_valid) begin
            fifo_instr[wr_ptr] <= rom_data;
            fifo_pc[wr_ptr]    <= inflight_pc;
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch
//   Directed and randomized bench for instr_fetch. The ROM is modelled here
//   as a registered lookup. The reference model is the architectural stream:
//   every accepted handshake must carry the next sequential PC since the last
//   redirect (or reset) and the ROM word stored at that PC.
// ---------------------------------------------------------------------------
module tb_instr_fetch;

    logic        clk;
    logic        rst_n;
    logic        fetch_en;
    logic [13:0] rom_addr;
    logic [31:0] rom_data = 32'd0;
    logic        redirect_valid;
    logic [13:0] redirect_pc;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [13:0] out_pc;
    logic        out_ready;

    int          n_pass   = 0;
    int          n_checks = 0;

    logic [13:0] exp_pc;
    logic [1:0]  redir_hist;
    logic [13:0] got_pc [$];
    int          mark;
    int          n8;

    instr_fetch #(
        .ADDR_W   (14),
        .RESET_PC (14'h0000),
        .DEPTH    (2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fetch_en       (fetch_en),
        .rom_addr       (rom_addr),
        .rom_data       (rom_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .out_ready      (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 4 KiB of populated ROM; anything above reads as zero.
    function automatic logic [31:0] rom_word(input logic [13:0] a);
        if (a == 14'h0000)      return 32'h00200193;
        else if (a == 14'h0004) return 32'h00000093;
        else if (a == 14'h0008) return 32'h0100026f;
        else if (a < 14'h1000)  return {a[11:0], 4'h3, a ^ 14'h2A5A, 2'b11};
        else                    return 32'd0;
    endfunction

    always @(posedge clk) rom_data <= rom_word(rom_addr);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Apply inputs for the next edge, score any handshake they complete,
    // advance one clock and sample 1 time unit after the edge.
    task automatic step(input logic fe, input logic rdy, input logic rv, input logic [13:0] rpc);
        fetch_en       = fe;
        out_ready      = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        if (out_valid && rdy) begin
            chk("stream_pc", 32'(out_pc), 32'(exp_pc));
            chk("stream_instr", out_instr, rom_word(exp_pc));
            got_pc.push_back(out_pc);
            exp_pc = exp_pc + 14'd4;
        end
        if (rv) exp_pc = {rpc[13:2], 2'b00};
        redir_hist = {redir_hist[0], rv};
        @(posedge clk);
        #1;
        if (redir_hist != 2'b00) chk("post_redirect_idle", 32'(out_valid), 32'd0);
        chk("count_le_depth", 32'(dut.count <= 2'd2), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst_n          = 1'b0;
        fetch_en       = 1'b0;
        out_ready      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 14'h0;
        exp_pc         = 14'h0;
        redir_hist     = 2'b00;
        #12;
        chk("reset_valid",    32'(out_valid), 32'd0);
        chk("reset_instr",    out_instr,      32'd0);
        chk("reset_pc",       32'(out_pc),    32'd0);
        chk("reset_rom_addr", 32'(rom_addr),  32'd0);
        rst_n = 1'b1;

        // streaming from reset
        step(1, 1, 0, 14'h0);
        chk("first_edge_idle", 32'(out_valid), 32'd0);
        step(1, 1, 0, 14'h0);
        chk("first_valid", 32'(out_valid), 32'd1);
        chk("first_pc",    32'(out_pc),    32'h0);
        chk("first_instr", out_instr,      32'h00200193);
        step(1, 1, 0, 14'h0);
        chk("second_valid", 32'(out_valid), 32'd1);
        chk("second_pc",    32'(out_pc),    32'h4);
        chk("second_instr", out_instr,      32'h00000093);
        step(1, 1, 0, 14'h0);
        chk("third_valid", 32'(out_valid), 32'd1);
        chk("third_pc",    32'(out_pc),    32'h8);
        chk("third_instr", out_instr,      32'h0100026f);

        // redirect while 0x08 is in flight
        step(1, 1, 1, 14'h000);
        step(1, 1, 0, 14'h0);
        step(1, 1, 0, 14'h0);
        chk("restart_pc", 32'(out_pc), 32'h0);
        step(1, 1, 0, 14'h0);
        chk("pre_redirect_head", 32'(out_pc), 32'h4);
        mark = got_pc.size();
        step(1, 1, 1, 14'h018);
        chk("redirect_idle0", 32'(out_valid), 32'd0);
        step(1, 1, 0, 14'h0);
        chk("redirect_idle1", 32'(out_valid), 32'd0);
        step(1, 1, 0, 14'h0);
        chk("redirect_valid", 32'(out_valid), 32'd1);
        chk("redirect_pc",    32'(out_pc),    32'h018);
        n8 = 0;
        for (int i = mark; i < got_pc.size(); i++) if (got_pc[i] == 14'h8) n8++;
        chk("redirect_drops_0x08", 32'(n8), 32'd0);

        // misaligned redirect target
        step(1, 1, 1, 14'h02E);
        step(1, 1, 0, 14'h0);
        step(1, 1, 0, 14'h0);
        chk("misaligned_valid", 32'(out_valid), 32'd1);
        chk("misaligned_pc",    32'(out_pc),    32'h02C);

        // backpressure
        step(1, 1, 1, 14'h000);
        step(1, 1, 0, 14'h0);
        step(1, 1, 0, 14'h0);
        for (int i = 0; i < 5; i++) begin
            step(1, 0, 0, 14'h0);
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_pc",    32'(out_pc),    32'h0);
            chk("bp_instr", out_instr,      32'h00200193);
        end
        chk("bp_rom_addr_frozen", 32'(rom_addr),  32'h8);
        chk("bp_count_full",      32'(dut.count), 32'd2);
        mark = got_pc.size();
        for (int i = 0; i < 3; i++) begin
            step(1, 1, 0, 14'h0);
            chk("bp_release_valid", 32'(out_valid), 32'd1);
        end
        chk("bp_release_n",  32'(got_pc.size() - mark), 32'd3);
        chk("bp_release_p0", 32'(got_pc[mark]),         32'h0);
        chk("bp_release_p1", 32'(got_pc[mark + 1]),     32'h4);
        chk("bp_release_p2", 32'(got_pc[mark + 2]),     32'h8);

        // redirect with pop while full, fetch_en toggling
        step(0, 0, 0, 14'h0);
        chk("full_before_flush", 32'(dut.count), 32'd2);
        step(0, 1, 1, 14'h040);
        chk("flush_empty",    32'(out_valid), 32'd0);
        chk("flush_rom_addr", 32'(rom_addr),  32'h040);
        step(1, 1, 0, 14'h0);
        step(0, 1, 0, 14'h0);
        chk("flush_next_valid", 32'(out_valid), 32'd1);
        chk("flush_next_pc",    32'(out_pc),    32'h040);
        step(1, 1, 0, 14'h0);
        step(0, 1, 0, 14'h0);
        chk("flush_follow_pc", 32'(out_pc), 32'h044);

        // back-to-back redirects
        step(1, 1, 1, 14'h100);
        step(1, 1, 1, 14'h200);
        step(1, 1, 0, 14'h0);
        step(1, 1, 0, 14'h0);
        chk("b2b_valid", 32'(out_valid), 32'd1);
        chk("b2b_pc",    32'(out_pc),    32'h200);

        // wrap past the top of the address space
        step(1, 1, 1, 14'h3FF8);
        step(1, 1, 0, 14'h0);
        step(1, 1, 0, 14'h0);
        chk("wrap_head", 32'(out_pc), 32'h3FF8);
        mark = got_pc.size();
        for (int i = 0; i < 3; i++) step(1, 1, 0, 14'h0);
        chk("wrap_p0", 32'(got_pc[mark]),     32'h3FF8);
        chk("wrap_p1", 32'(got_pc[mark + 1]), 32'h3FFC);
        chk("wrap_p2", 32'(got_pc[mark + 2]), 32'h0000);
        chk("wrap_head_after", 32'(out_pc), 32'h4);

        // fetch_en low: in-flight word lands, pc frozen
        step(0, 0, 0, 14'h0);
        chk("fe_low_rom_addr", 32'(rom_addr),  32'h00C);
        chk("fe_low_count",    32'(dut.count), 32'd2);
        step(0, 1, 0, 14'h0);
        chk("fe_low_rom_addr2", 32'(rom_addr), 32'h00C);
        chk("fe_low_head",      32'(out_pc),   32'h008);
        step(0, 1, 0, 14'h0);
        chk("fe_low_drained", 32'(out_valid), 32'd0);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 11) == 0, 14'($urandom_range(0, 16383)));
        end

        // asynchronous reset mid-stream
        step(1, 1, 1, 14'h080);
        step(1, 1, 0, 14'h0);
        step(1, 1, 0, 14'h0);
        chk("pre_reset_valid", 32'(out_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_valid",    32'(out_valid), 32'd0);
        chk("async_reset_pc",       32'(out_pc),    32'd0);
        chk("async_reset_instr",    out_instr,      32'd0);
        chk("async_reset_rom_addr", 32'(rom_addr),  32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
